// File: rtl/ahfp_norm.sv
// ahfp_norm: post-subtract normalisation for the single-precision subtract path.
// Takes the raw sign, biased exponent and unnormalised mantissa from the
// align-and-subtract stage, normalises it by one left shift per enabled
// cycle, and presents a packed IEEE-754 word (truncated, never denormal).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   clk_en                freezes all state when low
//   in_valid / in_ready   upstream handshake (in_ready high only when idle)
//   in_sign, in_exp       result sign and biased exponent
//   in_man                {carry, hidden, fraction}, already truncated
//   out_valid / out_ready downstream handshake
//   result                packed {sign, exp, fraction}
//   out_zero/unf/ovf      zero result / underflow flush / overflow to infinity
module ahfp_norm #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_man,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   out_zero,
  output logic                   out_unf,
  output logic                   out_ovf
);

  localparam int RES_W = EXP_W + MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [RES_W-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] f);
    return {s, e, f};
  endfunction

  // Overflow saturates to a signed infinity.
  function automatic logic [RES_W-1:0] sat_inf(input logic s);
    return {s, EXP_MAX, {MAN_W{1'b0}}};
  endfunction

  state_t             state, state_d;
  logic               sign_p0, sign_d;
  logic [EXP_W-1:0]   exp_p0, exp_d, exp_inc;
  logic [MAN_W:0]     man_p0, man_d;
  logic [RES_W-1:0]   result_d;
  logic               zero_d, unf_d, ovf_d;
  logic               need_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_d    = state;
    sign_d     = sign_p0;
    exp_d      = exp_p0;
    man_d      = man_p0;
    result_d   = result;
    zero_d     = out_zero;
    unf_d      = out_unf;
    ovf_d      = out_ovf;
    exp_inc    = in_exp + 1'b1;
    // Only an operand with no carry, no hidden bit and a usable exponent iterates.
    need_shift = (in_man != '0) && (in_exp != EXP_MAX) && (in_exp != EXP_ZERO) &&
                 (in_man[MAN_W+1:MAN_W] == 2'b00);

    if (clk_en) begin
      case (state)
        // Stage boundary: operand capture and single-cycle classification.
        IDLE: begin
          if (in_valid) begin
            sign_d = in_sign;
            exp_d  = in_exp;
            man_d  = in_man[MAN_W:0];
            if (need_shift) begin
              state_d = SHIFT;
            end else begin
              state_d = DONE;
              zero_d  = 1'b0;
              unf_d   = 1'b0;
              ovf_d   = 1'b0;
              if (in_man == '0) begin
                result_d = '0;
                zero_d   = 1'b1;
              end else if (in_exp == EXP_MAX) begin
                result_d = sat_inf(in_sign);
                ovf_d    = 1'b1;
              end else if (in_exp == EXP_ZERO) begin
                result_d = '0;
                zero_d   = 1'b1;
                unf_d    = 1'b1;
              end else if (in_man[MAN_W+1]) begin
                if (exp_inc == EXP_MAX) begin
                  result_d = sat_inf(in_sign);
                  ovf_d    = 1'b1;
                end else begin
                  result_d = pack(in_sign, exp_inc, in_man[MAN_W:1]);
                end
              end else begin
                result_d = pack(in_sign, in_exp, in_man[MAN_W-1:0]);
              end
            end
          end
        end
        // Stage boundary: iterative normalise; exponent doubles as shift count.
        SHIFT: begin
          if (man_p0[MAN_W]) begin
            result_d = pack(sign_p0, exp_p0, man_p0[MAN_W-1:0]);
            zero_d   = 1'b0;
            unf_d    = 1'b0;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else if (exp_p0 <= EXP_ONE) begin
            result_d = '0;
            zero_d   = 1'b1;
            unf_d    = 1'b1;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else begin
            man_d = {man_p0[MAN_W-1:0], 1'b0};
            exp_d = exp_p0 - 1'b1;
          end
        end
        // Stage boundary: result held until downstream accepts.
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sign_p0  <= 1'b0;
      exp_p0   <= '0;
      man_p0   <= '0;
      result   <= '0;
      out_zero <= 1'b0;
      out_unf  <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      state    <= state_d;
      sign_p0  <= sign_d;
      exp_p0   <= exp_d;
      man_p0   <= man_d;
      result   <= result_d;
      out_zero <= zero_d;
      out_unf  <= unf_d;
      out_ovf  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ahfp_norm.sv
// Scoreboard bench for ahfp_norm: the driver pushes model expectations on each
// accept, a separate monitor pops and compares on each output handshake.
module tb_ahfp_norm;

  logic        clk, reset, clk_en, in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_man;
  logic        out_valid, out_ready, out_zero, out_unf, out_ovf;
  logic [31:0] result;

  ahfp_norm #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_man(in_man),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_zero(out_zero), .out_unf(out_unf), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [31:0] res;
    logic        z, u, o;
    int          lat;   // enabled cycles spent in the shift loop (0 = direct)
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   mode = 0;       // 0: all enabled, 1: random enable/ready, 2: toggle clk_en, 3: manual
  int   cnt = 0;
  bit   seen_valid = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic u,
                              input logic o, input int lat);
    exp_t x;
    x.res = r; x.z = z; x.u = u; x.o = o; x.lat = lat;
    return x;
  endfunction

  // Reference: value-level normalisation using a leading-zero count.
  function automatic exp_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
    exp_t x;
    int k, ne;
    logic [24:0] mm;
    x = mk(32'h0, 1'b0, 1'b0, 1'b0, 0);
    if (m == 0) begin
      x.z = 1;
    end else if (e == 8'hFF) begin
      x.res = {s, 8'hFF, 23'h0}; x.o = 1;
    end else if (e == 0) begin
      x.z = 1; x.u = 1;
    end else if (m[24]) begin
      ne = int'(e) + 1;
      if (ne == 255) begin
        x.res = {s, 8'hFF, 23'h0}; x.o = 1;
      end else begin
        x.res = {s, ne[7:0], m[23:1]};
      end
    end else if (m[23]) begin
      x.res = {s, e, m[22:0]};
    end else begin
      k = 0;
      while (m[23-k] == 1'b0) k++;
      if (int'(e) - k >= 1) begin
        ne = int'(e) - k;
        mm = m << k;
        x.res = {s, ne[7:0], mm[22:0]};
        x.lat = k + 1;
      end else begin
        x.z = 1; x.u = 1;
        x.lat = int'(e);
      end
    end
    return x;
  endfunction

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input exp_t x);
    int t;
    logic [31:0] r;
    @(posedge clk); #2;
    in_valid = 1; in_sign = s; in_exp = e; in_man = m;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready && clk_en) break;
      t++;
      if (t > 400) begin
        check("accept_timeout", 64'(t), 64'(0));
        in_valid = 0;
        return;
      end
    end
    sbq.push_back(x);
    @(posedge clk); #2;
    r = $urandom;
    in_valid = 0; in_sign = r[31]; in_exp = r[30:23]; in_man = r[24:0];
  endtask

  task automatic sendm(input logic s, input logic [7:0] e, input logic [24:0] m);
    send(s, e, m, model(s, e, m));
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sbq.size()), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  // Stimulus driver for clk_en / out_ready.
  initial begin
    forever begin
      @(posedge clk); #2;
      case (mode)
        0: begin clk_en = 1; out_ready = 1; end
        1: begin clk_en = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0); end
        2: begin clk_en = ~clk_en; out_ready = 1; end
        default: ;
      endcase
    end
  end

  // Monitor: latency on first presentation, full compare on handshake.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid && !seen_valid) begin
          seen_valid = 1;
          check("in_ready_in_done", 64'(in_ready), 64'(0));
          if (sbq.size() == 0) check("unexpected_output", 64'(1), 64'(0));
          else check("shift_cycles", 64'(cnt), 64'(sbq[0].lat));
        end
        if (out_valid && out_ready && clk_en) begin
          seen_valid = 0;
          if (sbq.size() != 0) begin
            x = sbq.pop_front();
            check("result", 64'(result), 64'(x.res));
            check("out_zero", 64'(out_zero), 64'(x.z));
            check("out_unf", 64'(out_unf), 64'(x.u));
            check("out_ovf", 64'(out_ovf), 64'(x.o));
          end
        end
        if (!out_valid && !in_ready && clk_en) cnt++;
        if (in_ready && in_valid && clk_en) cnt = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  e;
    logic [24:0] m;
    int t;
    reset = 1; clk_en = 1; out_ready = 1; in_valid = 0;
    in_sign = 0; in_exp = 0; in_man = 0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_flags", 64'({out_zero, out_unf, out_ovf}), 64'(0));
    @(negedge clk); reset = 0;

    // Directed cases with hand-computed expectations.
    mode = 0;
    send(1, 8'h7F, 25'h0800000, mk(32'hBF800000, 0, 0, 0, 0));
    send(0, 8'h80, 25'h1000000, mk(32'h40800000, 0, 0, 0, 0));
    send(0, 8'hFE, 25'h1000000, mk(32'h7F800000, 0, 0, 1, 0));
    send(0, 8'h85, 25'h002CCCD, mk(32'h3FB33340, 0, 0, 0, 7));
    send(1, 8'h7F, 25'h0000000, mk(32'h00000000, 1, 0, 0, 0));
    send(0, 8'h03, 25'h0000001, mk(32'h00000000, 1, 1, 0, 3));
    send(1, 8'hFF, 25'h0800000, mk(32'hFF800000, 0, 0, 1, 0));
    send(1, 8'h00, 25'h0400000, mk(32'h00000000, 1, 1, 0, 0));
    send(0, 8'h18, 25'h0000001, mk(32'h00800000, 0, 0, 0, 24));
    send(0, 8'h17, 25'h0000001, mk(32'h00000000, 1, 1, 0, 23));
    send(1, 8'hFD, 25'h1FFFFFF, mk(32'hFF7FFFFF, 0, 0, 0, 0));
    send(0, 8'h80, 25'h1000001, mk(32'h40800000, 0, 0, 0, 0));
    drain();

    // Backpressure: hold out_ready low for five cycles in DONE.
    @(posedge clk); #2;
    mode = 3; clk_en = 1; out_ready = 0;
    send(0, 8'h80, 25'h1000000, mk(32'h40800000, 0, 0, 0, 0));
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    check("bp_out_valid", 64'(out_valid), 64'(1));
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_result", 64'(result), 64'(32'h40800000));
      check("bp_hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #2; out_ready = 1;
    @(posedge clk); #2; out_ready = 0;
    @(negedge clk);
    check("bp_released_in_ready", 64'(in_ready), 64'(1));
    check("bp_released_out_valid", 64'(out_valid), 64'(0));
    mode = 0;
    drain();

    // clk_en toggling mid-shift: same result and enabled-cycle count.
    mode = 2;
    send(0, 8'h85, 25'h002CCCD, mk(32'h3FB33340, 0, 0, 0, 7));
    drain();
    mode = 0;
    repeat (2) @(posedge clk);

    // Asynchronous reset while shifting.
    sendm(0, 8'h85, 25'h002CCCD);
    repeat (2) @(posedge clk);
    #3 reset = 1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_result", 64'(result), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    check("arst_flags", 64'({out_zero, out_unf, out_ovf}), 64'(0));
    sbq.delete();
    seen_valid = 0;
    #3 reset = 0;
    send(1, 8'h7F, 25'h0800000, mk(32'hBF800000, 0, 0, 0, 0));
    drain();

    // Randomized operands with random clk_en / out_ready.
    mode = 1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      e = r[7:0];
      r = $urandom;
      m = r[24:0];
      case ($urandom_range(0, 7))
        0: m = '0;
        1: e = 8'hFF;
        2: e = 8'h00;
        3: begin m[24] = 1'b1; e = 8'($urandom_range(1, 254)); end
        4: begin m[24:23] = 2'b01; e = 8'($urandom_range(1, 254)); end
        5: begin m = m >> $urandom_range(2, 24); e = 8'($urandom_range(1, 254)); end
        6: begin m = 25'h1 << $urandom_range(0, 22); e = 8'($urandom_range(1, 30)); end
        default: ;
      endcase
      sendm(r[31], e, m);
    end
    mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
